// File: rtl/riscv_trace_pkg.sv
// rtl/riscv_trace_pkg.sv - trace entry format, event kinds and FSM states (RISCV_TRACE_TS_EN adds ts)
package riscv_trace_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    REG   = 2'b01,
    STORE = 2'b10,
    LOAD  = 2'b11
  } trace_kind_e;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DRAIN = 2'b01,
    DONE  = 2'b10
  } trace_state_e;

  typedef struct packed {
`ifdef RISCV_TRACE_TS_EN
    logic [15:0] ts;
`endif
    logic [7:0]  seq;
    trace_kind_e kind;
    logic [8:0]  tag;
    logic [31:0] data;
  } trace_entry_t;

  localparam int ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous FIFO with registered head and push-while-full-if-popping
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 51
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/riscv_trace_buffer.sv
// rtl/riscv_trace_buffer.sv - commit-trace capture, encode and drain (RISCV_TRACE_TS_EN adds timestamp)
module riscv_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               reg_write_sig,
  input  logic [4:0]         reg_num,
  input  logic [31:0]        reg_data,
  input  logic               wr,
  input  logic               rd,
  input  logic [8:0]         addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [DATA_W-1:0]  rd_data,
  input  logic               Halt_riscv,
  output logic               trace_valid,
  input  logic               trace_ready,
  output logic [ENTRY_W-1:0] trace_data,
  output logic               trace_overflow,
  output logic [7:0]         drop_count,
  output logic               trace_done
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  trace_state_e     state;
  logic [7:0]       seq;
  trace_kind_e      kind;
  logic [8:0]       tag;
  logic [31:0]      data;
  trace_entry_t     entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             pop;
  logic             fire;
  logic             push;
  logic             drop;

`ifdef RISCV_TRACE_TS_EN
  logic [15:0] ts;

  always_ff @(posedge clk) begin
    if (reset) ts <= '0;
    else       ts <= ts + 16'd1;
  end
`endif

  // One event per cycle; a store outranks a load, and x0 writes never trace.
  always_comb begin
    kind = NONE;
    tag  = '0;
    data = '0;
    if (wr) begin
      kind = STORE;
      tag  = addr;
      data = 32'(wr_data);
    end else if (rd && reg_write_sig && reg_num != 5'd0) begin
      kind = LOAD;
      tag  = addr;
      data = 32'(rd_data);
    end else if (reg_write_sig && reg_num != 5'd0) begin
      kind = REG;
      tag  = {4'b0, reg_num};
      data = reg_data;
    end
  end

  always_comb begin
    entry      = '0;
`ifdef RISCV_TRACE_TS_EN
    entry.ts   = ts;
`endif
    entry.seq  = seq;
    entry.kind = kind;
    entry.tag  = tag;
    entry.data = data;
  end

  assign trace_valid = !fifo_empty;
  assign pop         = trace_valid && trace_ready;
  assign fire        = (state == RUN) && (kind != NONE);
  assign push        = fire && (!fifo_full || pop);
  assign drop        = fire && !push;

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (entry),
    .pop   (pop),
    .rdata (trace_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Dropped events still consume a seq value so gaps reveal the loss.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      seq            <= '0;
      trace_overflow <= 1'b0;
      drop_count     <= '0;
      trace_done     <= 1'b0;
    end else begin
      if (fire) seq <= seq + 8'd1;
      if (drop) begin
        trace_overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
      case (state)
        RUN: begin
          if (Halt_riscv) state <= DRAIN;
        end
        DRAIN: begin
          if (fifo_count == '0) begin
            state      <= DONE;
            trace_done <= 1'b1;
          end
        end
        DONE: begin
          trace_done <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: doc/riscv_trace_buffer.md
# riscv_trace_buffer

Commit-trace capture unit directly downstream of the `riscv` core top. Each cycle it samples the core's register-writeback and data-memory bus outputs. It encodes at most one trace event per cycle into a fixed-format entry and buffers entries in a FIFO. Entries drain over a valid/ready stream to a testbench or debug port. On `Halt_riscv` it stops capturing, drains, and signals completion.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 4..256.
- `DATA_W`, 32: data width; matches core.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `reg_write_sig` in 1: core register write this cycle.
- `reg_num` in 5: destination register.
- `reg_data` in 32: write-back value.
- `wr` in 1: data-memory store strobe.
- `rd` in 1: data-memory load strobe.
- `addr` in 9: data-memory address.
- `wr_data` in DATA_W: store data.
- `rd_data` in DATA_W: load data.
- `Halt_riscv` in 1: core halt.
- `trace_valid` out 1: `trace_data` holds an entry.
- `trace_ready` in 1: consumer accepts.
- `trace_data` out ENTRY_W: head entry; ENTRY_W=51, or 67 with timestamp.
- `trace_overflow` out 1: sticky; one or more events dropped.
- `drop_count` out 8: saturating count of dropped events.
- `trace_done` out 1: halt seen and FIFO empty.

## Operation
- Entry layout, MSB→LSB: `[ts(16)]`, `seq(8)`, `kind(2)`, `tag(9)`, `data(32)`.
- Event selection per cycle, priority order:
  - `wr`=1 → STORE (2'b10); tag=`addr`, data=`wr_data`.
  - `rd`=1 and `reg_write_sig`=1 and `reg_num`≠0 → LOAD (2'b11); tag=`addr`, data=`rd_data`.
  - `reg_write_sig`=1 and `reg_num`≠0 → REG (2'b01); tag={4'b0,`reg_num`}, data=`reg_data`.
  - Otherwise no event. Writes to x0 are never traced.
  - `rd` without a register write is ignored.
- `seq` increments by 1 per generated event, dropped ones included, and wraps 255→0. Gaps in `seq` therefore expose drops.
- FSM states RUN, DRAIN, DONE; reset state RUN.
  - RUN: capture events. On `Halt_riscv`=1 go to DRAIN; an event in the same cycle is still captured.
  - DRAIN: capture disabled; pops continue. When the FIFO is empty, go to DONE.
  - DONE: `trace_done`=1. Held until reset; `Halt_riscv` deassertion is ignored.
- Full condition: push accepted if count<DEPTH, or if a pop occurs in the same cycle. Otherwise the event is dropped, `trace_overflow` is set, and `drop_count`++ (saturates at 255).
- Pop occurs when `trace_valid`&&`trace_ready`.
- Empty FIFO: `trace_valid`=0, `trace_data` don't-care (implementation drives held head value).
- Pointers are log2(DEPTH) bits with natural wrap. Count is log2(DEPTH)+1 bits.

## Timing
- Inputs sampled at rising edge N. The entry is written at edge N. With the FIFO previously empty, `trace_valid`=1 during cycle N+1: one-cycle latency.
- FIFO fall-through is not used; `trace_data` is the registered head.
- Simultaneous push+pop when full: both occur, count is unchanged, no drop.
- Simultaneous push+pop when empty: the new entry appears next cycle; the pop is impossible since `trace_valid`=0.
- `trace_data` and `trace_valid` are held stable while `trace_valid`&&!`trace_ready`.
- Reset values:
  - `trace_valid`=0, `trace_overflow`=0, `drop_count`=0, `trace_done`=0.
  - `seq`=0, timestamp=0, pointers=0, state RUN.
- Reset mid-drain discards all buffered entries in the same cycle.
- `trace_done` rises one cycle after the last pop completes.

## Configuration
- `RISCV_TRACE_TS_EN` defined: a 16-bit free-running cycle counter (reset 0, wraps) is prepended to each entry, and ENTRY_W=67.
- Undefined: no counter, ENTRY_W=51, no `ts` field.

## Structure
- Package `riscv_trace_pkg` holds:
  - `trace_kind_e` (NONE=00, REG=01, STORE=10, LOAD=11).
  - `trace_entry_t` packed struct, with the `ts` field under `RISCV_TRACE_TS_EN`.
  - `ENTRY_W`.
  - FSM enum `trace_state_e`.
- Sub-module `trace_fifo`: synchronous FIFO parameterized by DEPTH and width, with push/pop/full/empty/count. The top holds event encode, seq/ts counters, overflow logic and FSM.

## Test plan
- Reset then `reg_write_sig`=1, `reg_num`=5, `reg_data`=32'hDEAD_BEEF, `trace_ready`=1 → next cycle `trace_valid`=1 with kind REG, tag=5, data=32'hDEAD_BEEF, seq=0.
- `reg_write_sig`=1, `reg_num`=0 → no entry; `trace_valid` stays 0, `seq` unchanged.
- `rd`=1, `reg_write_sig`=1, `reg_num`=7, `addr`=9'h1F0, `rd_data`=32'h1234 → one LOAD entry with tag=9'h1F0, data=32'h1234. Same cycle with `wr`=1 → STORE wins.
- `trace_ready`=0 with 20 consecutive REG events at DEPTH=16:
  - First 16 entries are stored; `trace_overflow`=1 and `drop_count`=4.
  - Draining yields seq 0..15.
  - The next event after the drain carries seq=20.
- Full FIFO with push and pop in the same cycle → no drop, count stays 16.
- 3 entries buffered, `Halt_riscv` pulsed, `trace_ready`=1 → 3 pops, later events are ignored, `trace_done`=1 one cycle after the final pop. `reset` asserted in DRAIN → all outputs return to reset values next cycle.
